// File: rtl/fan_pkg.sv
// Shared types and default constants for the fan temperature controller and
// the downstream PWM stage.
package fan_pkg;

  localparam int TEMP_W  = 8;
  localparam int SPEED_W = 8;

  localparam int DEF_T_LOW     = 25;
  localparam int DEF_T_CRIT    = 80;
  localparam int DEF_HYST      = 3;
  localparam int DEF_SPEED_MIN = 64;
  localparam int DEF_SLOPE     = 4;
  localparam int DEF_RAMP_STEP = 8;
  localparam int DEF_RAMP_DIV  = 1000;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_CRIT = 2'd2
  } fan_state_t;

  function automatic logic [SPEED_W-1:0] sat_speed(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/fan_temp_ctrl_if.sv
// Sample input and speed-command outputs of the fan controller.
// temp_valid is a one-cycle strobe with no ready: temp is taken on every clock edge where temp_valid is high.
interface fan_temp_ctrl_if;
  import fan_pkg::*;

  logic [TEMP_W-1:0]  temp;
  logic               temp_valid;
  logic [SPEED_W-1:0] speed;
  logic               fan_on;
  logic               alarm;
  logic [TEMP_W-1:0]  temp_filt;
  logic               filt_valid;
  fan_state_t         state;

  modport master (
    output temp, temp_valid,
    input  speed, fan_on, alarm, temp_filt, filt_valid, state
  );

  modport slave (
    input  temp, temp_valid,
    output speed, fan_on, alarm, temp_filt, filt_valid, state
  );
endinterface

// File: rtl/fan_temp_avg.sv
// 4-tap moving average. The first sample after reset fills every tap so the
// output starts at that sample instead of ramping up from zero.
module fan_temp_avg
  import fan_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic [TEMP_W-1:0] temp,
  input  logic              temp_valid,
  output logic [TEMP_W-1:0] filt,
  output logic              filt_valid
);

  logic [3:0][TEMP_W-1:0] taps;
  logic [9:0]             sum;
  logic                   filled;
  logic                   pend;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      taps       <= '0;
      sum        <= '0;
      filled     <= 1'b0;
      pend       <= 1'b0;
      filt       <= '0;
      filt_valid <= 1'b0;
    end else begin
      pend       <= temp_valid;
      filt_valid <= pend;
      if (pend) filt <= sum[9:2];
      if (temp_valid) begin
        if (!filled) begin
          taps   <= {4{temp}};
          sum    <= {temp, 2'b00};
          filled <= 1'b1;
        end else begin
          // Running sum: drop the oldest tap, add the new sample.
          taps <= {taps[2:0], temp};
          sum  <= sum - {2'b00, taps[3]} + {2'b00, temp};
        end
      end
    end
  end

endmodule

// File: rtl/fan_temp_ctrl.sv
// Filtered temperature to fan speed: hysteretic OFF/RUN/CRIT state machine,
// linear speed map and a slew-limited ramp that only moves on ramp ticks.
module fan_temp_ctrl
  import fan_pkg::*;
#(
  parameter int T_LOW     = DEF_T_LOW,
  parameter int T_CRIT    = DEF_T_CRIT,
  parameter int HYST      = DEF_HYST,
  parameter int SPEED_MIN = DEF_SPEED_MIN,
  parameter int SLOPE     = DEF_SLOPE,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int RAMP_DIV  = DEF_RAMP_DIV
) (
  input  logic            clk,
  input  logic            arst_n,
  fan_temp_ctrl_if.slave  bus
);

  localparam int CW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

  logic [TEMP_W-1:0]  filt;
  logic               filt_valid;
  fan_state_t         state_q, state_n;
  logic [SPEED_W-1:0] speed_q, speed_n, target, ramp;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic               fan_on_q, alarm_q, tick;
  logic [15:0]        target_wide;

  fan_temp_avg u_avg (
    .clk        (clk),
    .arst_n     (arst_n),
    .temp       (bus.temp),
    .temp_valid (bus.temp_valid),
    .filt       (filt),
    .filt_valid (filt_valid)
  );

  always_comb begin
    target_wide = 16'(SPEED_MIN);
    if (filt >= 8'(T_LOW))
      target_wide = 16'(SPEED_MIN) + (16'(filt) - 16'(T_LOW)) * 16'(SLOPE);
    target = sat_speed(target_wide);
  end

  always_comb begin
    ramp = speed_q;
    if (target >= speed_q) begin
      if (target - speed_q <= 8'(RAMP_STEP)) ramp = target;
      else                                   ramp = speed_q + 8'(RAMP_STEP);
    end else begin
      if (speed_q - target <= 8'(RAMP_STEP)) ramp = target;
      else                                   ramp = speed_q - 8'(RAMP_STEP);
    end
  end

  assign tick = (cnt_q == CW'(RAMP_DIV - 1));

  // The ramp counter only runs while staying in RUN, so every RUN entry starts a full tick period.
  always_comb begin
    state_n = state_q;
    speed_n = speed_q;
    cnt_n   = '0;
    unique case (state_q)
      ST_OFF: begin
        if (filt >= 8'(T_CRIT)) begin
          state_n = ST_CRIT;
          speed_n = 8'hFF;
        end else if (filt >= 8'(T_LOW)) begin
          state_n = ST_RUN;
          speed_n = 8'(SPEED_MIN);
        end
      end
      ST_RUN: begin
        if (filt >= 8'(T_CRIT)) begin
          state_n = ST_CRIT;
          speed_n = 8'hFF;
        end else if (filt < 8'(T_LOW - HYST)) begin
          state_n = ST_OFF;
          speed_n = '0;
        end else if (tick) begin
          speed_n = ramp;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      ST_CRIT: begin
        if (filt < 8'(T_CRIT - HYST)) state_n = ST_RUN;
      end
      default: begin
        state_n = ST_OFF;
        speed_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= ST_OFF;
      speed_q  <= '0;
      cnt_q    <= '0;
      fan_on_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      speed_q  <= speed_n;
      cnt_q    <= cnt_n;
      fan_on_q <= (state_n != ST_OFF);
      alarm_q  <= (state_n == ST_CRIT);
    end
  end

  assign bus.speed      = speed_q;
  assign bus.fan_on     = fan_on_q;
  assign bus.alarm      = alarm_q;
  assign bus.temp_filt  = filt;
  assign bus.filt_valid = filt_valid;
  assign bus.state      = state_q;

endmodule
